auth_attempt_limiter: RTL

- Sits directly downstream of the 8-bit secret/input comparator and consumes its `match` result per authentication attempt.
- Returns a grant/deny response after a fixed latency that does not depend on the data, so response timing does not reveal the comparison outcome or secret bits.
- Counts consecutive failures and enforces a timed lockout.
- During lockout, attempts are still accepted and answered with identical timing, but are always denied.

---
 rtl/auth_attempt_limiter_pkg.sv | 19 +
 rtl/auth_attempt_limiter_lockout_timer.sv | 62 ++++++
 rtl/auth_attempt_limiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/auth_attempt_limiter_pkg.sv
// auth_pkg: shared types and constants for the authentication attempt limiter.
//   auth_state_e : response FSM states (IDLE, WAIT, RESP)
//   FAIL_CNT_W   : width of the consecutive-failure counter
//   esc_lvl_t    : lockout escalation level (used only with AUTH_LIMITER_ESCALATE_EN)
package auth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } auth_state_e;

  localparam int                    FAIL_CNT_W   = 4;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = '1;

  typedef logic [1:0] esc_lvl_t;
  localparam esc_lvl_t ESC_LVL_MAX = 2'd3;

endpackage

// File: rtl/auth_attempt_limiter_lockout_timer.sv
// auth_lockout_timer: lock flag plus lockout down-counter.
// Optional macro AUTH_LIMITER_ESCALATE_EN: each consecutive lockout doubles
// the duration (1x, 2x, 4x, 8x, saturating), cleared by any grant.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_arm                start a lockout on the next edge
//   i_clear_escalation   a grant happened; drop escalation back to 1x
//   o_locked             lockout active
module auth_lockout_timer
  import auth_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 256,
  parameter int LOCK_W         = $clog2(LOCKOUT_CYCLES*8+1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_arm,
  input  logic i_clear_escalation,
  output logic o_locked
);

  logic              r_locked;
  logic [LOCK_W-1:0] r_timer;
  logic [LOCK_W-1:0] w_load;

`ifdef AUTH_LIMITER_ESCALATE_EN
  esc_lvl_t r_esc;

  assign w_load = LOCK_W'(LOCKOUT_CYCLES) << r_esc;

  // Level used for this lockout is the current one; bump afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_esc <= '0;
    else if (i_clear_escalation) r_esc <= '0;
    else if (i_arm && r_esc != ESC_LVL_MAX) r_esc <= r_esc + esc_lvl_t'(1);
  end
`else
  logic w_unused_clear;
  assign w_unused_clear = i_clear_escalation;
  assign w_load         = LOCK_W'(LOCKOUT_CYCLES);
`endif

  // Timer is loaded on the arming edge and counts down while locked. The lock
  // drops on the edge that takes the timer to zero, so o_locked is high for
  // exactly w_load cycles; the final locked cycle is the one where the timer
  // is about to hit zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_locked <= 1'b0;
      r_timer  <= '0;
    end else if (i_arm) begin
      r_locked <= 1'b1;
      r_timer  <= w_load;
    end else if (r_locked) begin
      r_timer <= r_timer - LOCK_W'(1);
      if (r_timer <= LOCK_W'(1)) r_locked <= 1'b0;
    end
  end

  assign o_locked = r_locked;

endmodule

// File: rtl/auth_attempt_limiter.sv
// auth_attempt_limiter: fixed-latency grant/deny responder behind the secret
// comparator, with consecutive-failure counting and timed lockout.
// Response latency is independent of the match result and of lockout state.
// Optional macro AUTH_LIMITER_ESCALATE_EN (see auth_lockout_timer).
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_req_valid / o_req_ready    attempt handshake; i_match_in is its payload
//   o_resp_valid / i_resp_ready  response handshake; o_resp_grant is payload
//   o_locked                     lockout active
//   o_fail_count                 consecutive-failure count
module auth_attempt_limiter
  import auth_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int RESP_LATENCY   = 8,
  parameter int LOCKOUT_CYCLES = 256,
  parameter int LOCK_W         = $clog2(LOCKOUT_CYCLES*8+1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_match_in,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic                  o_resp_grant,
  output logic                  o_locked,
  output logic [FAIL_CNT_W-1:0] o_fail_count
);

  localparam int                    CNT_W    = $clog2(RESP_LATENCY);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(RESP_LATENCY-1);
  localparam logic [FAIL_CNT_W-1:0] FAIL_LIM = FAIL_CNT_W'(MAX_FAILS);

  auth_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_lat_cnt;
  logic                  r_grant_q, r_acc_locked;
  logic [FAIL_CNT_W-1:0] r_fail_cnt, w_fail_inc;
  logic                  w_accept, w_resp_hs, w_arm, w_clear_esc, w_locked;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_req_valid)       w_state_nxt = WAIT;
      WAIT:    if (r_lat_cnt == '0)   w_state_nxt = RESP;
      RESP:    if (i_resp_ready)      w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_req_ready  = (r_state == IDLE);
    o_resp_valid = (r_state == RESP);
    o_resp_grant = (r_state == RESP) & r_grant_q;
  end

  assign w_accept  = i_req_valid & o_req_ready;
  assign w_resp_hs = o_resp_valid & i_resp_ready;

  // Decision and lock status are frozen at accept, so the response held in
  // RESP never changes even if the lockout expires while it waits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lat_cnt    <= '0;
      r_grant_q    <= 1'b0;
      r_acc_locked <= 1'b0;
    end else if (w_accept) begin
      r_lat_cnt    <= CNT_LOAD;
      r_grant_q    <= i_match_in & ~w_locked;
      r_acc_locked <= w_locked;
    end else if (r_state == WAIT && r_lat_cnt != '0) begin
      r_lat_cnt <= r_lat_cnt - CNT_W'(1);
    end
  end

  assign w_fail_inc  = (r_fail_cnt == FAIL_CNT_MAX) ? r_fail_cnt
                                                    : r_fail_cnt + FAIL_CNT_W'(1);
  // Attempts accepted during lockout never touch the accounting.
  assign w_arm       = w_resp_hs & ~r_acc_locked & ~r_grant_q & (w_fail_inc >= FAIL_LIM);
  assign w_clear_esc = w_resp_hs & r_grant_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fail_cnt <= '0;
    end else if (w_resp_hs && !r_acc_locked) begin
      if (r_grant_q || w_arm) r_fail_cnt <= '0;
      else                    r_fail_cnt <= w_fail_inc;
    end
  end

  auth_lockout_timer #(
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .LOCK_W         (LOCK_W)
  ) u_lockout (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_arm              (w_arm),
    .i_clear_escalation (w_clear_esc),
    .o_locked           (w_locked)
  );

  assign o_locked     = w_locked;
  assign o_fail_count = r_fail_cnt;

endmodule
